// File: rtl/ssi_frm_tx.sv
// SSI frame transmitter: 32-bit word FIFO feeding a 4-lane serial port.
// Frames of FRM_WORDS words, each preceded by a one-bit FSS pulse.
module ssi_frm_tx #(
  parameter int CLK_DIV   = 4,
  parameter int FIFO_AW   = 4,
  parameter int FRM_WORDS = 8,
  parameter int GAP_BITS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [31:0] din,
  output logic        din_ready,
  input  logic        tx_en,
  input  logic        clr_ovf,
  output logic        ssi_clk,
  output logic        ssi_fss,
  output logic [3:0]  ssi_xdat,
  output logic        busy,
  output logic        ovf
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int DW    = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int WW    = (FRM_WORDS > 1) ? $clog2(FRM_WORDS + 1) : 1;
  localparam int GW    = (GAP_BITS > 1) ? $clog2(GAP_BITS + 1) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, GAP} state_t;

  state_t state, state_nxt;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [31:0]        sh;
  logic [DW-1:0]      div_cnt;
  logic [2:0]         bit_cnt;
  logic [WW-1:0]      word_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               push, pop, bit_end, shifting;

  assign din_ready = (count != CW'(DEPTH));
  assign push      = din_valid && din_ready;
  assign bit_end   = (div_cnt == DW'(2 * CLK_DIV - 1));
  assign shifting  = (state == SYNC) || (state == SHIFT);

  assign busy     = (state != IDLE);
  assign ssi_clk  = shifting && (div_cnt >= DW'(CLK_DIV));
  assign ssi_fss  = (state == SYNC);
  assign ssi_xdat = (state == SHIFT) ? {sh[31], sh[23], sh[15], sh[7]}
                                     : 4'd0;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_en && count >= CW'(FRM_WORDS)) begin
          state_nxt = SYNC;
          pop       = 1'b1;
        end
      end
      SYNC: begin
        if (bit_end) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (bit_end && bit_cnt == 3'd7) begin
          if (word_cnt == WW'(FRM_WORDS - 1)) state_nxt = GAP;
          else                                pop       = 1'b1;
        end
      end
      GAP: begin
        if (bit_end && gap_cnt == GW'(GAP_BITS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      sh       <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // a dropped write in the same cycle as a clear keeps the flag
      if (din_valid && !din_ready) ovf <= 1'b1;
      else if (clr_ovf)            ovf <= 1'b0;
      if (pop)
        sh <= mem[rd_ptr];
      else if (state == SHIFT && bit_end)
        sh <= {sh[30:24], 1'b0, sh[22:16], 1'b0,
               sh[14:8], 1'b0, sh[6:0], 1'b0};
      if (state == IDLE || bit_end) div_cnt <= '0;
      else                          div_cnt <= div_cnt + 1'b1;
      if (state != SHIFT)  bit_cnt <= '0;
      else if (bit_end)    bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE)
        word_cnt <= '0;
      else if (state == SHIFT && bit_end && bit_cnt == 3'd7)
        word_cnt <= word_cnt + 1'b1;
      if (state != GAP)  gap_cnt <= '0;
      else if (bit_end)  gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ssi_frm_tx.sv
// Directed bench for ssi_frm_tx with CLK_DIV=2, FRM_WORDS=2, GAP_BITS=2.
// Frame outputs are checked cycle by cycle against a bit-timing model.
module tb_ssi_frm_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [31:0] din;
  logic        din_ready;
  logic        tx_en;
  logic        clr_ovf;
  logic        ssi_clk;
  logic        ssi_fss;
  logic [3:0]  ssi_xdat;
  logic        busy;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  logic [15:0] l3, l0;

  ssi_frm_tx #(
    .CLK_DIV(2), .FIFO_AW(4), .FRM_WORDS(2), .GAP_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .tx_en(tx_en), .clr_ovf(clr_ovf),
    .ssi_clk(ssi_clk), .ssi_fss(ssi_fss), .ssi_xdat(ssi_xdat),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entry: at the negedge of the first SYNC cycle.
  task automatic run_frame(input logic [31:0] w0, input logic [31:0] w1,
                           input int drop_at,
                           output logic [15:0] o3, output logic [15:0] o0);
    logic [31:0] w;
    logic [6:0]  e;
    int p, ph, i, b;
    o3 = '0;
    o0 = '0;
    for (int t = 0; t < 76; t++) begin
      p  = t / 4;
      ph = t % 4;
      e  = '0;
      e[6] = 1'b1;
      e[5] = (p <= 16) && (ph >= 2);
      e[4] = (p == 0);
      if (p >= 1 && p <= 16) begin
        i = p - 1;
        w = (i < 8) ? w0 : w1;
        b = i % 8;
        for (int k = 0; k < 4; k++) e[k] = w[8 * k + 7 - b];
      end
      chk($sformatf("frame_t%0d", t),
          {25'd0, busy, ssi_clk, ssi_fss, ssi_xdat}, {25'd0, e});
      if (p >= 1 && p <= 16 && ph == 2) begin
        o3 = {o3[14:0], ssi_xdat[3]};
        o0 = {o0[14:0], ssi_xdat[0]};
      end
      if (t == drop_at) tx_en = 1'b0;
      step();
    end
    chk("frame_end", {25'd0, busy, ssi_clk, ssi_fss, ssi_xdat}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] w);
    din_valid = 1'b1;
    din       = w;
    step();
    din_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0; tx_en = 1'b0; clr_ovf = 1'b0;

    // 1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_outs", {28'd0, ssi_clk, ssi_fss, ssi_xdat}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    // 2: basic 2-word frame
    wr(32'hA5C30F81);
    wr(32'h12345678);
    chk("idle_no_en", {31'd0, busy}, 32'd0);
    tx_en = 1'b1;
    step();
    run_frame(32'hA5C30F81, 32'h12345678, -1, l3, l0);
    chk("lane3", {16'd0, l3}, 32'h0000A512);
    chk("lane0", {16'd0, l0}, 32'h00008178);
    tx_en = 1'b0;

    // 3: full FIFO and overflow
    for (int n = 0; n < 16; n++) begin
      din_valid = 1'b1;
      din = n * 32'h01010101;
      step();
      chk($sformatf("fill_ready%0d", n), {31'd0, din_ready},
          (n < 15) ? 32'd1 : 32'd0);
    end
    chk("ovf_pre", {31'd0, ovf}, 32'd0);
    step();
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    din_valid = 1'b0;
    clr_ovf = 1'b1;
    step();
    chk("ovf_clr", {31'd0, ovf}, 32'd0);
    din_valid = 1'b1;
    step();
    chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
    din_valid = 1'b0;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr2", {31'd0, ovf}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush_count", {27'd0, dut.count}, 32'd0);
    chk("flush_ready", {31'd0, din_ready}, 32'd1);

    // 4: tx_en dropped during first frame of four queued words
    wr(32'h11223344);
    wr(32'h55667788);
    wr(32'h99AABBCC);
    wr(32'hDDEEFF00);
    tx_en = 1'b1;
    step();
    run_frame(32'h11223344, 32'h55667788, 0, l3, l0);
    chk("drop_count", {27'd0, dut.count}, 32'd2);
    for (int n = 0; n < 12; n++) begin
      step();
      chk($sformatf("drop_idle%0d", n), {31'd0, busy}, 32'd0);
    end
    tx_en = 1'b1;
    step();
    run_frame(32'h99AABBCC, 32'hDDEEFF00, -1, l3, l0);
    tx_en = 1'b0;

    // 5: reset during SHIFT bit 5
    wr(32'hCAFEF00D);
    wr(32'h0BADBEEF);
    tx_en = 1'b1;
    step();
    chk("r5_sync", {31'd0, ssi_fss}, 32'd1);
    repeat (25) step();
    chk("r5_midframe", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_en = 1'b0;
    chk("r5_outs", {27'd0, busy, ssi_clk, ssi_fss, ssi_xdat}, 32'd0);
    chk("r5_count", {27'd0, dut.count}, 32'd0);
    wr(32'h3C3C5A5A);
    wr(32'hF0E1D2C3);
    tx_en = 1'b1;
    step();
    run_frame(32'h3C3C5A5A, 32'hF0E1D2C3, -1, l3, l0);
    tx_en = 1'b0;

    // 6: frame waits for a full frame's worth of words
    tx_en = 1'b1;
    wr(32'h80000001);
    step();
    chk("one_word_idle", {31'd0, busy}, 32'd0);
    step();
    chk("one_word_idle2", {31'd0, busy}, 32'd0);
    wr(32'h7F00FF80);
    chk("two_words_idle", {31'd0, busy}, 32'd0);
    step();
    run_frame(32'h80000001, 32'h7F00FF80, -1, l3, l0);
    tx_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
